// File: rtl/sync_fifo_unit_if.sv
// Signal bundle between sync_fifo_unit and its controller (push/pop strobes, data, pointers, overrides).
// A push happens at an edge where w_en is high, full is low and no w_ptr override is requested; a pop likewise with r_en/empty/r_ptr override.
interface sync_fifo_unit_if #(
   parameter int DEPTH     = 8,
   parameter int WIDTH     = 8,
   parameter int PTR_WIDTH = $clog2(DEPTH) + 1
);
   logic                 r_en;
   logic [0:WIDTH-1]     dout;
   logic [0:PTR_WIDTH-1] r_ptr;
   logic                 w_en;
   logic [0:WIDTH-1]     din;
   logic [0:PTR_WIDTH-1] w_ptr;
   logic                 full;
   logic                 empty;
   logic                 r_fail;
   logic                 w_fail;
   logic                 change_r_ptr_en;
   logic [0:PTR_WIDTH-1] change_r_ptr_value;
   logic                 change_w_ptr_en;
   logic [0:PTR_WIDTH-1] change_w_ptr_value;

   modport master (
      output r_en, w_en, din,
      output change_r_ptr_en, change_r_ptr_value, change_w_ptr_en, change_w_ptr_value,
      input  dout, r_ptr, w_ptr, full, empty, r_fail, w_fail
   );

   modport slave (
      input  r_en, w_en, din,
      input  change_r_ptr_en, change_r_ptr_value, change_w_ptr_en, change_w_ptr_value,
      output dout, r_ptr, w_ptr, full, empty, r_fail, w_fail
   );
endinterface

// File: rtl/sync_fifo_unit.sv
// Single-clock first-word-fall-through FIFO with exposed wrap-bit pointers and
// direct pointer reload, used for rollback of reorder/issue queues on flush.
module sync_fifo_unit #(
   parameter int DEPTH      = 8,
   parameter int WIDTH      = 8,
   parameter int PTR_WIDTH  = $clog2(DEPTH) + 1,
   parameter int RESET_MODE = 0
) (
   input logic             clk,
   input logic             reset,
   sync_fifo_unit_if.slave bus
);
   localparam int IDX_W = PTR_WIDTH - 1;

   logic [0:PTR_WIDTH-1] r_rd_ptr;
   logic [0:PTR_WIDTH-1] r_wr_ptr;
   logic [0:WIDTH-1]     r_mem [0:DEPTH-1];

   logic [0:IDX_W-1] w_rd_idx;
   logic [0:IDX_W-1] w_wr_idx;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;

   // Bit 0 of each pointer is the wrap bit; the remaining bits index storage.
   assign w_rd_idx = r_rd_ptr[1:PTR_WIDTH-1];
   assign w_wr_idx = r_wr_ptr[1:PTR_WIDTH-1];
   assign w_empty  = (r_rd_ptr == r_wr_ptr);
   assign w_full   = (r_rd_ptr[0] != r_wr_ptr[0]) && (w_rd_idx == w_wr_idx);

   // An override owns its pointer for the cycle, suppressing the access it shadows.
   assign w_push = bus.w_en && !w_full  && !bus.change_w_ptr_en;
   assign w_pop  = bus.r_en && !w_empty && !bus.change_r_ptr_en;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
      end else if (bus.change_w_ptr_en) begin
         r_wr_ptr <= bus.change_w_ptr_value;
      end else if (w_push) begin
         r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd_ptr <= '0;
      end else if (bus.change_r_ptr_en) begin
         r_rd_ptr <= bus.change_r_ptr_value;
      end else if (w_pop) begin
         r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
      end
   end

   generate
      if (RESET_MODE != 0) begin : g_mem_clear
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int i = 0; i < DEPTH; i++) begin
                  r_mem[i] <= '0;
               end
            end else if (w_push) begin
               r_mem[w_wr_idx] <= bus.din;
            end
         end
      end else begin : g_mem_keep
         always_ff @(posedge clk) begin
            if (w_push) begin
               r_mem[w_wr_idx] <= bus.din;
            end
         end
      end
   endgenerate

   assign bus.dout   = r_mem[w_rd_idx];
   assign bus.r_ptr  = r_rd_ptr;
   assign bus.w_ptr  = r_wr_ptr;
   assign bus.full   = w_full;
   assign bus.empty  = w_empty;
   assign bus.r_fail = bus.r_en && w_empty;
   assign bus.w_fail = bus.w_en && w_full;
endmodule

// File: tb/tb_sync_fifo_unit.sv
// Directed plus randomized bench for sync_fifo_unit against an occupancy/array reference model.
module tb_sync_fifo_unit;
   localparam int DEPTH     = 8;
   localparam int WIDTH     = 8;
   localparam int PTR_WIDTH = 4;
   localparam int PTR_MOD   = 16;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   sync_fifo_unit_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .PTR_WIDTH(PTR_WIDTH)) bus ();

   sync_fifo_unit #(
      .DEPTH(DEPTH), .WIDTH(WIDTH), .PTR_WIDTH(PTR_WIDTH), .RESET_MODE(1)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model / scoreboard ----------------
   logic [WIDTH-1:0] m_mem [DEPTH];
   int               m_rp;
   int               m_wp;
   logic [WIDTH-1:0] exp_q [$];
   bit               q_track = 1'b0;

   function automatic int occ();
      return (m_wp - m_rp + PTR_MOD) % PTR_MOD;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_rp = 0;
      m_wp = 0;
      exp_q.delete();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step_ovr(input logic re, input logic we, input logic [WIDTH-1:0] d,
                           input logic cre, input logic [PTR_WIDTH-1:0] crv,
                           input logic cwe, input logic [PTR_WIDTH-1:0] cwv);
      logic e;
      logic f;
      bus.r_en               = re;
      bus.w_en               = we;
      bus.din                = d;
      bus.change_r_ptr_en    = cre;
      bus.change_r_ptr_value = crv;
      bus.change_w_ptr_en    = cwe;
      bus.change_w_ptr_value = cwv;
      #1;
      e = (occ() == 0);
      f = (occ() == DEPTH);
      chk("empty",  bus.empty,  e);
      chk("full",   bus.full,   f);
      chk("r_fail", bus.r_fail, re && e);
      chk("w_fail", bus.w_fail, we && f);
      chk("dout",   bus.dout,   m_mem[m_rp % DEPTH]);
      chk("r_ptr",  bus.r_ptr,  m_rp);
      chk("w_ptr",  bus.w_ptr,  m_wp);
      if (q_track && re && !e && !cre) begin
         if (exp_q.size() == 0) chk("order_underflow", 32'd1, 32'd0);
         else                   chk("order", bus.dout, exp_q.pop_front());
      end
      if (cwe) m_wp = int'(cwv);
      else if (we && !f) begin
         m_mem[m_wp % DEPTH] = d;
         if (q_track) exp_q.push_back(d);
         m_wp = (m_wp + 1) % PTR_MOD;
      end
      if (cre) m_rp = int'(crv);
      else if (re && !e) m_rp = (m_rp + 1) % PTR_MOD;
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic re, input logic we, input logic [WIDTH-1:0] d);
      step_ovr(re, we, d, 1'b0, '0, 1'b0, '0);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      bus.r_en = 1'b1; bus.w_en = 1'b0; bus.din = '0;
      bus.change_r_ptr_en = 1'b0; bus.change_r_ptr_value = '0;
      bus.change_w_ptr_en = 1'b0; bus.change_w_ptr_value = '0;
      reset = 1'b0;
      model_reset();
      #1;
      chk("rst_r_ptr",  bus.r_ptr,  0);
      chk("rst_w_ptr",  bus.w_ptr,  0);
      chk("rst_empty",  bus.empty,  1);
      chk("rst_full",   bus.full,   0);
      chk("rst_dout",   bus.dout,   0);
      chk("rst_r_fail", bus.r_fail, 1);
      chk("rst_w_fail", bus.w_fail, 0);
      bus.r_en = 1'b0;
      @(posedge clk); @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;

      // din toggles with w_en low: nothing may change
      for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 8'(i));
      // fill to full, then 8 rejected writes
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(16 + i));
      // drain to empty, then 8 rejected reads
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'h00);
      // w_ptr override beats a concurrent write
      step_ovr(1'b0, 1'b1, 8'd10, 1'b0, 4'd0, 1'b1, 4'd5);
      // r_ptr override beats a concurrent read
      step_ovr(1'b1, 1'b0, 8'd0, 1'b1, 4'd5, 1'b0, 4'd0);

      // wrap + simultaneous traffic with order tracking
      q_track = 1'b1;
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'($urandom));
      for (int i = 0; i < 3; i++)     step(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 10; i++)    step(1'b1, 1'b1, 8'($urandom));

      // asynchronous reset mid-stream, held across an edge with both requests active
      bus.r_en = 1'b1; bus.w_en = 1'b1; bus.din = 8'hA5;
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      chk("mid_rst_r_ptr",  bus.r_ptr,  0);
      chk("mid_rst_w_ptr",  bus.w_ptr,  0);
      chk("mid_rst_empty",  bus.empty,  1);
      chk("mid_rst_r_fail", bus.r_fail, 1);
      chk("mid_rst_dout",   bus.dout,   0);
      @(posedge clk); #1;
      chk("rst_hold_w_ptr", bus.w_ptr,  0);
      chk("rst_hold_r_ptr", bus.r_ptr,  0);
      chk("rst_hold_dout",  bus.dout,   0);
      bus.r_en = 1'b0; bus.w_en = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 8'($urandom));

      // randomized traffic including occasional pointer overrides
      q_track = 1'b0;
      for (int i = 0; i < 300; i++) begin
         step_ovr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                  ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
